output_layer_grad_engine: RTL

//  Backward pass for the softmax output layer of the 2-layer classifier.
//  - Consumes per-sample softmax probabilities, the class label and the hidden-layer ReLU activations.
//  - Computes delta[j] = prob[j] - onehot(label)[j], then accumulates dW2[j][k] += delta[j]*act[k] and dB2[j] += delta[j] over BATCH samples.
//  - Presents the accumulated gradients to the weight-update logic through a valid/ack handshake.

---
 rtl/output_layer_grad_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/output_layer_grad_engine.sv
// ============================================================================
// output_layer_grad_engine
//
// Backward pass for the softmax output layer of a 2-layer classifier.
// Each accepted sample yields delta[j] = prob[j] - onehot(label)[j]. The
// engine then spends HIDDEN1 cycles folding that sample into
//   dW2[j][k] += (delta[j] * act[k]) >>> FRAC   (one column k per cycle,
//                                                 all rows j in parallel)
//   dB2[j]    += delta[j]                        (on the k == 0 cycle)
// After BATCH samples the gradients are held in DONE, with grad_valid high,
// until the consumer pulses grad_ack. The ack clears every accumulator.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst_n       synchronous reset, active-low
//   in_valid    sample presented
//   in_ready    sample accepted when in_valid & in_ready (high only in IDLE)
//   in_probs    softmax outputs, OUT_SIZE x signed Q.FRAC
//   in_label    true class index; a label >= OUT_SIZE adds no one-hot term
//   in_act      hidden-layer ReLU activations, HIDDEN1 x signed Q.FRAC
//   busy        high whenever the engine is not in IDLE
//   sample_cnt  samples fully accumulated in the current batch
//   grad_valid  gradients complete and stable (DONE)
//   grad_ack    consumer finished reading; ignored outside DONE
//   grad_w      accumulated dW2, OUT_SIZE x HIDDEN1 x signed ACC_W
//   grad_b      accumulated dB2, OUT_SIZE x signed ACC_W
//
// Build option
//   GRAD_SAT_EN  when defined, every accumulator add saturates to the signed
//                ACC_W range. When undefined, every add wraps modulo 2^ACC_W.
// ============================================================================
module output_layer_grad_engine #(
    parameter int HIDDEN1  = 64,
    parameter int OUT_SIZE = 3,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int BATCH    = 15,
    parameter int ACC_W    = 24,
    localparam int LBL_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
    localparam int CNT_W   = $clog2(BATCH + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [OUT_SIZE-1:0][WIDTH-1:0]            in_probs,
    input  logic [LBL_W-1:0]                          in_label,
    input  logic [HIDDEN1-1:0][WIDTH-1:0]             in_act,
    output logic                                      busy,
    output logic [CNT_W-1:0]                          sample_cnt,
    output logic                                      grad_valid,
    input  logic                                      grad_ack,
    output logic [OUT_SIZE-1:0][HIDDEN1-1:0][ACC_W-1:0] grad_w,
    output logic [OUT_SIZE-1:0][ACC_W-1:0]            grad_b
);

    localparam int K_W    = (HIDDEN1 > 1) ? $clog2(HIDDEN1) : 1;
    localparam int PROD_W = 2 * WIDTH + 1;

    // ONE in Q.FRAC, sized to the delta width.
    localparam logic [WIDTH:0] ONE = {{(WIDTH - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [K_W-1:0]                  k;
    logic [OUT_SIZE-1:0][WIDTH:0]    delta;
    logic [OUT_SIZE-1:0][WIDTH:0]    delta_in;
    logic [HIDDEN1-1:0][WIDTH-1:0]   act;
    logic                            last_k;
    logic                            batch_full;

    assign last_k     = (k == K_W'(HIDDEN1 - 1));
    // The sample now in MAC will bring the count up to BATCH.
    assign batch_full = (sample_cnt == CNT_W'(BATCH - 1));

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Full-precision product, floor-shifted back to Q.FRAC, resized to ACC_W.
    function automatic logic [ACC_W-1:0] mul_term(input logic [WIDTH:0]   d,
                                                  input logic [WIDTH-1:0] a);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        prod    = PROD_W'($signed(d)) * PROD_W'($signed(a));
        shifted = prod >>> FRAC;
        return ACC_W'(shifted);
    endfunction

    // One extra bit of headroom exposes the overflow. The low ACC_W bits are
    // the wrapped result.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W-1:0] term);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
`ifdef GRAD_SAT_EN
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                              : {1'b0, {(ACC_W - 1){1'b1}}};
        end
`endif
        return sum[ACC_W-1:0];
    endfunction

    // delta[j] = prob[j] - ONE on the label row only. An out-of-range label
    // matches no row, so delta is then simply the probabilities.
    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            delta_in[j] = {in_probs[j][WIDTH-1], in_probs[j]};
            if (in_label == LBL_W'(j)) begin
                delta_in[j] = delta_in[j] - ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so that every
        // always_ff reads the pre-edge values, matching real flip-flops.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output is given a default first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        grad_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (last_k) begin
                    state_next = batch_full ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                grad_valid = 1'b1;
                if (grad_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sample capture
    // ------------------------------------------------------------------
    // NOTE: the captured delta/act operands are deliberately left without a
    // reset. They are always written on accept before MAC reads them.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && in_valid) begin
            delta <= delta_in;
            act   <= in_act;
        end
    end

    // ------------------------------------------------------------------
    // Accumulators, column index and sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grad_w     <= '0;
            grad_b     <= '0;
            sample_cnt <= '0;
            k          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        k <= '0;
                    end
                end
                S_MAC: begin
                    for (int j = 0; j < OUT_SIZE; j++) begin
                        grad_w[j][k] <= acc_add(grad_w[j][k], mul_term(delta[j], act[k]));
                        if (k == '0) begin
                            grad_b[j] <= acc_add(grad_b[j], ACC_W'($signed(delta[j])));
                        end
                    end
                    k <= k + 1'b1;
                    if (last_k) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (grad_ack) begin
                        grad_w     <= '0;
                        grad_b     <= '0;
                        sample_cnt <= '0;
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

endmodule
